// File: rtl/flash_op_seq_pkg.sv
// Shared types for the flash operation sequencer: op codes, FSM states and
// the address-width helper.
package flash_op_seq_pkg;

    typedef enum logic [1:0] {
        OpRead    = 2'd0,
        OpProg    = 2'd1,
        OpPgErase = 2'd2,
        OpBkErase = 2'd3
    } op_type_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

    function automatic int unsigned addr_width(input int unsigned pages,
                                               input int unsigned words);
        return $clog2(pages) + $clog2(words);
    endfunction

endpackage

// File: rtl/flash_op_seq_rdbuf.sv
// Single-entry read-data buffer between the flash primitive and the
// rd_valid/rd_ready consumer.
module flash_op_seq_rdbuf
    import flash_op_seq_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o
);

    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;

    // The sequencer never pushes while the entry is occupied.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/flash_op_seq.sv
// Flash operation sequencer: splits READ/PROG/erase commands into primitive
// flash accesses. Optional WAIT watchdog enabled by FLASH_OP_SEQ_TIMEOUT_EN.
module flash_op_seq
    import flash_op_seq_pkg::*;
#(
    parameter  int unsigned PagesPerBank  = 256,
    parameter  int unsigned WordsPerPage  = 256,
    parameter  int unsigned DataWidth     = 32,
    parameter  int unsigned TimeoutCycles = 1024,
    localparam int unsigned AddrW         = addr_width(PagesPerBank, WordsPerPage),
    localparam int unsigned WordW         = $clog2(WordsPerPage),
    localparam int unsigned LenW          = WordW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [1:0]           op_type_i,
    input  logic [AddrW-1:0]     op_addr_i,
    input  logic [LenW-1:0]      op_len_i,
    input  logic                 prog_valid_i,
    output logic                 prog_ready_o,
    input  logic [DataWidth-1:0] prog_data_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic                 op_done_o,
    output logic                 op_err_o,
    output logic                 flash_req_o,
    output logic                 flash_rd_o,
    output logic                 flash_prog_o,
    output logic                 flash_pg_erase_o,
    output logic                 flash_bk_erase_o,
    output logic [AddrW-1:0]     flash_addr_o,
    output logic [DataWidth-1:0] flash_prog_data_o,
    input  logic                 flash_rd_done_i,
    input  logic                 flash_prog_done_i,
    input  logic                 flash_erase_done_i,
    input  logic [DataWidth-1:0] flash_rd_data_i,
    input  logic                 flash_init_busy_i
);

    state_e               state_q, state_d;
    op_type_e             type_q, type_d;
    logic [AddrW-1:0]     addr_q, addr_d;
    logic [LenW-1:0]      cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 have_q, have_d;
    logic [DataWidth-1:0] pdata_q, pdata_d;

    logic                 done_match, issue_go, tmo_expired, rdbuf_push, prog_overflow;
    logic [LenW:0]        span;

    // Word offset within the page plus the number of words to program.
    assign span = (LenW+1)'(op_addr_i[WordW-1:0]) + (LenW+1)'(op_len_i) + (LenW+1)'(1);
    assign prog_overflow = span > (LenW+1)'(WordsPerPage);

    always_comb begin
        case (type_q)
            OpRead:  done_match = flash_rd_done_i;
            OpProg:  done_match = flash_prog_done_i;
            default: done_match = flash_erase_done_i;
        endcase
    end

    always_comb begin
        case (type_q)
            OpRead:  issue_go = !rd_valid_o;
            OpProg:  issue_go = have_q;
            default: issue_go = 1'b1;
        endcase
    end

`ifdef FLASH_OP_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;

    assign tmo_d       = (state_q == StWait && !done_match) ? tmo_q + TmoW'(1) : '0;
    assign tmo_expired = state_q == StWait && !done_match &&
                         tmo_q == TmoW'(TimeoutCycles - 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_expired = 1'b0;
`endif

    assign op_ready_o        = state_q == StIdle && !flash_init_busy_i && !rst_i;
    assign prog_ready_o      = state_q == StIssue && type_q == OpProg && !have_q && prog_valid_i;
    assign flash_req_o       = (state_q == StIssue && issue_go) || state_q == StWait;
    assign flash_rd_o        = flash_req_o && type_q == OpRead;
    assign flash_prog_o      = flash_req_o && type_q == OpProg;
    assign flash_pg_erase_o  = flash_req_o && type_q == OpPgErase;
    assign flash_bk_erase_o  = flash_req_o && type_q == OpBkErase;
    assign flash_addr_o      = flash_req_o ? addr_q : '0;
    assign flash_prog_data_o = flash_prog_o ? pdata_q : '0;
    // A READ only completes once its last word has left the buffer.
    assign op_done_o         = state_q == StDone && !rd_valid_o;
    assign op_err_o          = op_done_o && err_q;
    assign rdbuf_push        = state_q == StWait && type_q == OpRead && flash_rd_done_i;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        have_d  = have_q;
        pdata_d = pdata_q;
        unique case (state_q)
            StIdle: begin
                if (op_valid_i && op_ready_o) begin
                    type_d = op_type_e'(op_type_i);
                    cnt_d  = op_len_i;
                    err_d  = 1'b0;
                    have_d = 1'b0;
                    addr_d = op_addr_i;
                    if (op_type_i == OpPgErase) begin
                        addr_d = {op_addr_i[AddrW-1:WordW], WordW'(0)};
                        cnt_d  = '0;
                    end else if (op_type_i == OpBkErase) begin
                        addr_d = '0;
                        cnt_d  = '0;
                    end
                    if (op_type_i == OpProg && prog_overflow) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (prog_ready_o) begin
                    pdata_d = prog_data_i;
                    have_d  = 1'b1;
                end else if (issue_go) begin
                    have_d  = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (done_match) begin
                    if (cnt_q != '0) begin
                        cnt_d   = cnt_q - LenW'(1);
                        addr_d  = addr_q + AddrW'(1);
                        state_d = StIssue;
                    end else begin
                        state_d = StDone;
                    end
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (op_done_o) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            type_q  <= OpRead;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            have_q  <= 1'b0;
            pdata_q <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            have_q  <= have_d;
            pdata_q <= pdata_d;
        end
    end

    flash_op_seq_rdbuf #(
        .DataWidth(DataWidth)
    ) u_rdbuf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (rdbuf_push),
        .data_i (flash_rd_data_i),
        .valid_o(rd_valid_o),
        .ready_i(rd_ready_i),
        .data_o (rd_data_o)
    );

endmodule

// File: tb/tb_flash_op_seq.sv
// Directed bench for flash_op_seq: vector table of whole commands plus
// hand-written sequences for back-pressure, WAIT holding, reset and timeout.
module tb_flash_op_seq;
    import flash_op_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic [1:0]  op_type_i = 2'd0;
    logic [15:0] op_addr_i = '0;
    logic [8:0]  op_len_i = '0;
    logic        prog_valid_i = 1'b0;
    logic        prog_ready_o;
    logic [31:0] prog_data_i = '0;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b1;
    logic [31:0] rd_data_o;
    logic        op_done_o, op_err_o;
    logic        flash_req_o, flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o;
    logic [15:0] flash_addr_o;
    logic [31:0] flash_prog_data_o;
    logic        flash_rd_done_i = 1'b0;
    logic        flash_prog_done_i = 1'b0;
    logic        flash_erase_done_i = 1'b0;
    logic [31:0] flash_rd_data_i = '0;
    logic        flash_init_busy_i = 1'b0;

    always #5 clk_i = ~clk_i;

    flash_op_seq #(
        .PagesPerBank (256),
        .WordsPerPage (256),
        .DataWidth    (32),
        .TimeoutCycles(16)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .op_valid_i        (op_valid_i),
        .op_ready_o        (op_ready_o),
        .op_type_i         (op_type_i),
        .op_addr_i         (op_addr_i),
        .op_len_i          (op_len_i),
        .prog_valid_i      (prog_valid_i),
        .prog_ready_o      (prog_ready_o),
        .prog_data_i       (prog_data_i),
        .rd_valid_o        (rd_valid_o),
        .rd_ready_i        (rd_ready_i),
        .rd_data_o         (rd_data_o),
        .op_done_o         (op_done_o),
        .op_err_o          (op_err_o),
        .flash_req_o       (flash_req_o),
        .flash_rd_o        (flash_rd_o),
        .flash_prog_o      (flash_prog_o),
        .flash_pg_erase_o  (flash_pg_erase_o),
        .flash_bk_erase_o  (flash_bk_erase_o),
        .flash_addr_o      (flash_addr_o),
        .flash_prog_data_o (flash_prog_data_o),
        .flash_rd_done_i   (flash_rd_done_i),
        .flash_prog_done_i (flash_prog_done_i),
        .flash_erase_done_i(flash_erase_done_i),
        .flash_rd_data_i   (flash_rd_data_i),
        .flash_init_busy_i (flash_init_busy_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor state, written only by the monitor/responder process (and clear()).
    int          cyc = 0, n_acc, acc_cyc, n_req, req_cyc, n_prdy, n_done, done_cyc, done_nrd;
    logic        done_err, req_prev = 1'b0;
    logic [15:0] first_addr, last_addr;
    logic [3:0]  first_strb;
    logic [31:0] last_pdata;
    logic [31:0] rd_q[$];
    bit          resp_en = 1'b0;
    logic [2:0]  man_pulse = 3'b000;
    int          age = 0;

    task automatic clear();
        n_acc = 0; acc_cyc = 0; n_req = 0; req_cyc = 0; n_prdy = 0;
        n_done = 0; done_cyc = 0; done_nrd = 0; done_err = 1'b0;
        first_addr = '0; last_addr = '0; first_strb = '0; last_pdata = '0;
        rd_q.delete();
    endtask

    // Monitor first, then flash responder answering each request 2 cycles later.
    initial begin
        clear();
        forever begin
            @(negedge clk_i);
            cyc++;
            if (op_valid_i && op_ready_o) begin
                n_acc++;
                acc_cyc = cyc;
            end
            if (flash_req_o && !req_prev) begin
                n_req++;
                if (n_req == 1) begin
                    first_addr = flash_addr_o;
                    first_strb = {flash_bk_erase_o, flash_pg_erase_o, flash_prog_o, flash_rd_o};
                    req_cyc    = cyc;
                end
                last_addr  = flash_addr_o;
                last_pdata = flash_prog_data_o;
            end
            req_prev = flash_req_o;
            if (prog_ready_o) n_prdy++;
            if (rd_valid_o && rd_ready_i) rd_q.push_back(rd_data_o);
            if (op_done_o) begin
                n_done++;
                done_err = op_err_o;
                done_cyc = cyc;
                done_nrd = rd_q.size();
            end
            flash_rd_done_i    = 1'b0;
            flash_prog_done_i  = 1'b0;
            flash_erase_done_i = 1'b0;
            if (man_pulse != 3'b000) begin
                {flash_erase_done_i, flash_prog_done_i, flash_rd_done_i} = man_pulse;
                man_pulse = 3'b000;
            end else if (resp_en && flash_req_o) begin
                age++;
                if (age == 2) begin
                    age = 0;
                    if (flash_rd_o) begin
                        flash_rd_done_i = 1'b1;
                        flash_rd_data_i = 32'hD00D_0000 | 32'(flash_addr_o);
                    end
                    if (flash_prog_o) flash_prog_done_i = 1'b1;
                    if (flash_pg_erase_o || flash_bk_erase_o) flash_erase_done_i = 1'b1;
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [15:0] addr, input logic [8:0] len);
        bit ok = 1'b0;
        @(posedge clk_i); #1;
        op_valid_i = 1'b1;
        op_type_i  = op;
        op_addr_i  = addr;
        op_len_i   = len;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (op_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
        check("op_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (n_done > 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("op_done_seen", 64'(ok), 64'd1);
        repeat (3) @(negedge clk_i);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [8:0]  len;
        logic        err;
        int          nreq;
        logic [15:0] a0;
        logic [15:0] alast;
        logic [3:0]  strb;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{OpRead,    16'h0100, 9'd3,   1'b0, 4,   16'h0100, 16'h0103, 4'b0001, 1};
        vecs[1] = '{OpProg,    16'h01FE, 9'd2,   1'b1, 0,   16'h0000, 16'h0000, 4'b0000, 0};
        vecs[2] = '{OpProg,    16'h01FE, 9'd1,   1'b0, 2,   16'h01FE, 16'h01FF, 4'b0010, 2};
        vecs[3] = '{OpPgErase, 16'h0345, 9'd5,   1'b0, 1,   16'h0300, 16'h0300, 4'b0100, 1};
        vecs[4] = '{OpBkErase, 16'h1234, 9'd0,   1'b0, 1,   16'h0000, 16'h0000, 4'b1000, 1};
        vecs[5] = '{OpRead,    16'hFFFF, 9'd1,   1'b0, 2,   16'hFFFF, 16'h0000, 4'b0001, 1};
        vecs[6] = '{OpProg,    16'h00FF, 9'd0,   1'b0, 1,   16'h00FF, 16'h00FF, 4'b0010, 2};
        vecs[7] = '{OpProg,    16'h00FF, 9'd1,   1'b1, 0,   16'h0000, 16'h0000, 4'b0000, 0};
        vecs[8] = '{OpProg,    16'h0000, 9'd256, 1'b1, 0,   16'h0000, 16'h0000, 4'b0000, 0};
        vecs[9] = '{OpProg,    16'h0300, 9'd255, 1'b0, 256, 16'h0300, 16'h03FF, 4'b0010, 2};

        // Reset values.
        repeat (3) @(negedge clk_i);
        check("rst_op_ready", 64'(op_ready_o), 64'd0);
        check("rst_flash_req", 64'({flash_req_o, flash_rd_o, flash_prog_o, flash_pg_erase_o,
                                    flash_bk_erase_o}), 64'd0);
        check("rst_flash_addr", 64'(flash_addr_o), 64'd0);
        check("rst_rd", 64'({rd_valid_o, rd_data_o}), 64'd0);
        check("rst_done_err", 64'({op_done_o, op_err_o, prog_ready_o}), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        flash_init_busy_i = 1'b1;
        @(negedge clk_i);
        check("init_busy_ready", 64'(op_ready_o), 64'd0);
        @(posedge clk_i); #1;
        flash_init_busy_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready", 64'(op_ready_o), 64'd1);

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            clear();
            resp_en      = 1'b1;
            rd_ready_i   = 1'b1;
            prog_valid_i = 1'b1;
            prog_data_i  = 32'hBEEF_0000 | 32'(i);
            start_op(vecs[i].op, vecs[i].addr, vecs[i].len);
            wait_done(3000);
            prog_valid_i = 1'b0;
            check($sformatf("v%0d_done_count", i), 64'(n_done), 64'd1);
            check($sformatf("v%0d_err", i), 64'(done_err), 64'(vecs[i].err));
            check($sformatf("v%0d_nreq", i), 64'(n_req), 64'(vecs[i].nreq));
            check($sformatf("v%0d_prog_ready", i), 64'(n_prdy),
                  64'(vecs[i].op == OpProg ? vecs[i].nreq : 0));
            check($sformatf("v%0d_rd_words", i), 64'(rd_q.size()),
                  64'(vecs[i].op == OpRead ? vecs[i].nreq : 0));
            if (vecs[i].nreq > 0) begin
                check($sformatf("v%0d_first_addr", i), 64'(first_addr), 64'(vecs[i].a0));
                check($sformatf("v%0d_last_addr", i), 64'(last_addr), 64'(vecs[i].alast));
                check($sformatf("v%0d_strobe", i), 64'(first_strb), 64'(vecs[i].strb));
                check($sformatf("v%0d_latency", i), 64'(req_cyc - acc_cyc), 64'(vecs[i].lat));
            end
            if (vecs[i].op == OpProg && vecs[i].nreq > 0) begin
                check($sformatf("v%0d_prog_data", i), 64'(last_pdata),
                      64'(32'hBEEF_0000 | 32'(i)));
            end
            for (int j = 0; j < rd_q.size(); j++) begin
                check($sformatf("v%0d_rd_data%0d", i, j), 64'(rd_q[j]),
                      64'(32'hD00D_0000 | 32'(16'(vecs[i].a0 + 16'(j)))));
            end
        end

        // Read back-pressure: second request held until first word is taken.
        begin
            bit seen = 1'b0;
            clear();
            resp_en    = 1'b1;
            rd_ready_i = 1'b0;
            start_op(OpRead, 16'h0200, 9'd1);
            for (int i = 0; i < 50; i++) begin
                @(negedge clk_i);
                if (rd_valid_o) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("bp_rd_valid", 64'(seen), 64'd1);
            repeat (10) @(negedge clk_i);
            check("bp_nreq_held", 64'(n_req), 64'd1);
            check("bp_rd_hold", 64'({rd_valid_o, rd_data_o}), 64'({1'b1, 32'hD00D_0200}));
            check("bp_no_done", 64'(n_done), 64'd0);
            @(posedge clk_i); #1;
            rd_ready_i = 1'b1;
            wait_done(200);
            check("bp_nreq", 64'(n_req), 64'd2);
            check("bp_words_at_done", 64'(done_nrd), 64'd2);
            check("bp_err", 64'(done_err), 64'd0);
            if (rd_q.size() == 2) check("bp_word1", 64'(rd_q[1]), 64'(32'hD00D_0201));
        end

        // Page erase held in WAIT; mismatched dones and new commands ignored.
        clear();
        resp_en = 1'b0;
        start_op(OpPgErase, 16'h0345, 9'd0);
        repeat (5) @(negedge clk_i);
        check("pe_hold", 64'({flash_req_o, flash_rd_o, flash_prog_o, flash_pg_erase_o,
                              flash_bk_erase_o}), 64'(5'b10010));
        check("pe_addr", 64'(flash_addr_o), 64'h0300);
        @(posedge clk_i); #1;
        op_valid_i = 1'b1;
        op_type_i  = OpRead;
        repeat (3) @(negedge clk_i);
        check("pe_busy_ready", 64'(op_ready_o), 64'd0);
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
        man_pulse = 3'b001;
        repeat (2) @(posedge clk_i); #1;
        man_pulse = 3'b010;
        repeat (3) @(negedge clk_i);
        check("pe_mismatch_hold", 64'({flash_pg_erase_o, flash_addr_o}), 64'({1'b1, 16'h0300}));
        check("pe_mismatch_nodone", 64'(n_done), 64'd0);
        @(posedge clk_i); #1;
        man_pulse = 3'b100;
        wait_done(50);
        check("pe_acc", 64'(n_acc), 64'd1);
        check("pe_err", 64'(done_err), 64'd0);

        // Reset mid-WAIT of a program.
        clear();
        resp_en      = 1'b0;
        prog_valid_i = 1'b1;
        start_op(OpProg, 16'h0010, 9'd3);
        repeat (4) @(negedge clk_i);
        check("rw_prog_wait", 64'({flash_req_o, flash_prog_o}), 64'(2'b11));
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rw_ready_in_rst", 64'(op_ready_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rw_strobes", 64'({flash_req_o, flash_rd_o, flash_prog_o, flash_pg_erase_o,
                                 flash_bk_erase_o, prog_ready_o}), 64'd0);
        check("rw_ready", 64'(op_ready_o), 64'd1);
        prog_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("rw_no_done", 64'(n_done), 64'd0);

        // Unanswered request: watchdog or indefinite WAIT.
        clear();
        resp_en = 1'b0;
        start_op(OpBkErase, 16'h0000, 9'd0);
`ifdef FLASH_OP_SEQ_TIMEOUT_EN
        wait_done(100);
        check("tmo_err", 64'(done_err), 64'd1);
        check("tmo_cycles", 64'(done_cyc - req_cyc), 64'd17);
        check("tmo_strobes", 64'(flash_req_o), 64'd0);
`else
        repeat (40) @(negedge clk_i);
        check("notmo_hold", 64'({flash_req_o, flash_bk_erase_o}), 64'(2'b11));
        check("notmo_no_done", 64'(n_done), 64'd0);
        @(posedge clk_i); #1;
        man_pulse = 3'b100;
        wait_done(50);
        check("notmo_err", 64'(done_err), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flash_op_seq.md
FLASH_OP_SEQ -- requirements
Module: flash_op_seq

Interface
REQ-001 SHALL have parameter PagesPerBank, default 256, pages per bank.
REQ-002 SHALL have parameter WordsPerPage, default 256, words per page.
REQ-003 SHALL have parameter DataWidth, default 32, flash word width.
REQ-004 SHALL have parameter TimeoutCycles, default 1024, watchdog limit (used only with the timeout feature); derived AddrW = clog2(PagesPerBank) + clog2(WordsPerPage).
REQ-005 SHALL have ports, clock and reset first; one clock; reset is synchronous and active-high:
- clk_i  in  1  sole clock
- rst_i  in  1  synchronous active-high reset
- op_valid_i  in  1  command request
- op_ready_o  out  1  command accepted when high with op_valid_i
- op_type_i  in  2  0=READ, 1=PROG, 2=PG_ERASE, 3=BK_ERASE
- op_addr_i  in  AddrW  start word address
- op_len_i  in  clog2(WordsPerPage)+1  word count minus 1 (READ/PROG only)
- prog_valid_i / prog_ready_o  in/out  1  program-data handshake
- prog_data_i  in  DataWidth  program word
- rd_valid_o / rd_ready_i  out/in  1  read-data handshake
- rd_data_o  out  DataWidth  read word
- op_done_o  out  1  one-cycle completion pulse
- op_err_o  out  1  error qualifier, valid only with op_done_o
- flash_req_o, flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o  out  1  primitive controls
- flash_addr_o  out  AddrW  primitive address
- flash_prog_data_o  out  DataWidth  primitive program data
- flash_rd_done_i, flash_prog_done_i, flash_erase_done_i  in  1  primitive completion pulses
- flash_rd_data_i  in  DataWidth  primitive read data, valid with flash_rd_done_i
- flash_init_busy_i  in  1  primitive initialising

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-007 op_ready_o SHALL be high only in IDLE with flash_init_busy_i low; op_valid_i at other times SHALL be ignored (not queued).
REQ-008 On acceptance SHALL latch type, address and remaining count, then enter ISSUE next cycle.
REQ-009 PROG with (addr mod WordsPerPage) + op_len_i + 1 > WordsPerPage SHALL go directly to DONE with op_err_o=1 and no flash access.
REQ-010 ISSUE: READ waits until the read buffer is empty; PROG waits for prog_valid_i, asserts prog_ready_o one cycle and captures the word; then flash_req_o plus exactly one op strobe assert and state goes to WAIT.
REQ-011 In WAIT flash_req_o, strobe, flash_addr_o and flash_prog_data_o SHALL stay stable until the matching done pulse; mismatched done pulses SHALL be ignored.
REQ-012 On the matching done, strobes SHALL drop that same cycle's next edge; if words remain the address SHALL increment by 1 (modulo 2^AddrW) and return to ISSUE, else go to DONE.
REQ-013 Read buffer: one entry; flash_rd_data_i captured on flash_rd_done_i; rd_valid_o rises the next cycle and holds until rd_ready_i.
REQ-014 DONE SHALL pulse op_done_o for exactly one cycle, then return to IDLE; READ completion SHALL wait until the last word is taken from the buffer.
REQ-015 PG_ERASE SHALL use the page of op_addr_i with word bits zeroed; BK_ERASE SHALL drive address 0; both ignore op_len_i and complete on flash_erase_done_i.
REQ-016 Minimum latency: op accept to first flash_req_o = 1 cycle (READ/erase), 2 cycles (PROG with data present).

Reset
REQ-017 rst_i SHALL return the FSM to IDLE from any state, including mid-WAIT, dropping all strobes next edge.
REQ-018 Reset values: all flash_* outputs 0, op_ready_o 0 during reset, prog_ready_o 0, rd_valid_o 0, rd_data_o 0, op_done_o 0, op_err_o 0.

Configuration
REQ-019 With FLASH_OP_SEQ_TIMEOUT_EN defined, a counter SHALL count WAIT cycles, clear on each done, and at TimeoutCycles drop strobes and go to DONE with op_err_o=1.
REQ-020 Without FLASH_OP_SEQ_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL persist indefinitely.

Structure
REQ-021 Op-type enum, FSM state enum and AddrW helper SHALL live in shared package flash_op_seq_pkg.
REQ-022 The read buffer SHALL be sub-module flash_op_seq_rdbuf; the FSM and counters stay in the top.

Verification
REQ-023 READ addr 0x0100, len 3, done 2 cycles after each req, rd_ready_i always 1 -> four words from 0x0100-0x0103 in order, one op_done_o, op_err_o=0.
REQ-024 PROG addr 0x01FE, len 2 -> op_done_o with op_err_o=1, flash_req_o never asserted, prog_ready_o never asserted.
REQ-025 READ len 1 with rd_ready_i held 0 for 10 cycles -> second flash_req_o not issued until first word taken; op_done_o after second word taken.
REQ-026 PG_ERASE addr 0x0345 -> flash_addr_o=0x0300, flash_pg_erase_o held until flash_erase_done_i; op_valid_i during WAIT ignored.
REQ-027 rst_i for one cycle mid-WAIT of PROG -> all strobes 0 next cycle, op_ready_o 1 once rst_i low and flash_init_busy_i low, no op_done_o.
REQ-028 With FLASH_OP_SEQ_TIMEOUT_EN, TimeoutCycles=16, no done returned -> op_done_o with op_err_o=1 exactly 16 WAIT cycles after req.
